// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
//   scan_state_t : scan FSM states
//   SYNC_STAGES  : depth of the column-input synchronizer
//   key_w()      : width of a key code for a rows x cols matrix
package keypad_pkg;

    typedef enum logic {
        S_SCAN = 1'b0,
        S_EVAL = 1'b1
    } scan_state_t;

    localparam int SYNC_STAGES = 2;

    // Clamped to 1 so a degenerate 1x1 matrix still gets a legal vector.
    function automatic int key_w(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/keypad_event_buf.sv
// One-entry valid/ready buffer for debounced key events.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   ev_valid      one-cycle strobe: new key event
//   ev_code       code of the new event
//   ready         consumer ready
//   valid         event pending (registered, never combinational on ready)
//   code          pending key code, held stable while valid
//   overflow      one-cycle pulse when an event is dropped because the entry is occupied
module keypad_event_buf #(
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ev_valid,
    input  logic [KW-1:0] ev_code,
    input  logic          ready,
    output logic          valid,
    output logic [KW-1:0] code,
    output logic          overflow
);

    logic slot_free;

    // The entry counts as free if it is empty or being drained this cycle.
    assign slot_free = !valid || ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            code     <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (ev_valid) begin
                if (slot_free) begin
                    valid <= 1'b1;
                    code  <= ev_code;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Time-multiplexed ROWS x COLS key-matrix scanner with frame debounce.
// One row is driven low per slot, the synchronized columns are sampled at the
// end of the slot, and after the last row a one-cycle evaluation step debounces
// the whole frame and emits at most one press event into a one-entry buffer.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_SCAN | row row_idx driven low; slot_cnt counts down to sample point
// S_EVAL | all rows released; frame snapshot debounced, event generated
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   row_o        row drive, active-low, at most one bit low
//   col_i        column sense, active-low, asynchronous
//   key_valid_o  key event pending
//   key_code_o   row*COLS + col of the pending event
//   key_ready_i  consumer accepts when valid & ready
//   multi_o      last evaluated frame had more than one key pressed
//   overflow_o   one-cycle pulse: event dropped, buffer full
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [ROWS-1:0]              row_o,
    input  logic [COLS-1:0]              col_i,
    output logic                         key_valid_o,
    output logic [key_w(ROWS, COLS)-1:0] key_code_o,
    input  logic                         key_ready_i,
    output logic                         multi_o,
    output logic                         overflow_o
);

    localparam int NK  = ROWS * COLS;
    localparam int KW  = key_w(ROWS, COLS);
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW  = $clog2(SCAN_DIV);
    localparam int STW = $clog2(DEBOUNCE_SCANS + 1);

    scan_state_t     state, state_nxt;
    logic [RW-1:0]   row_idx, row_nxt;
    logic [SW-1:0]   slot_cnt, slot_nxt;
    logic            have_frame;

    logic [COLS-1:0] col_sync [SYNC_STAGES];
    logic [COLS-1:0] col_pressed;

    logic [NK-1:0]   snapshot;
    logic [NK-1:0]   prev_frame;
    logic [NK-1:0]   deb_state;
    logic [STW-1:0]  stable_cnt;

    int              key_cnt;
    logic            multi_now;
    logic            same_frame;
    logic [KW-1:0]   hit_code;
    logic            do_eval;
    logic            stable_hit;
    logic            ev_valid;

    // Column synchronizer; idle (pulled-up) level after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                col_sync[i] <= '1;
            end
        end else begin
            col_sync[0] <= col_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                col_sync[i] <= col_sync[i-1];
            end
        end
    end

    assign col_pressed = ~col_sync[SYNC_STAGES-1];

    // Reset parks the FSM in S_EVAL so all rows stay released during reset
    // and row 0 is driven on the first cycle afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_EVAL;
            row_idx  <= '0;
            slot_cnt <= SW'(SCAN_DIV - 1);
        end else begin
            state    <= state_nxt;
            row_idx  <= row_nxt;
            slot_cnt <= slot_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row_idx;
        slot_nxt  = slot_cnt;
        case (state)
            S_SCAN: begin
                if (slot_cnt == '0) begin
                    slot_nxt = SW'(SCAN_DIV - 1);
                    if (row_idx == RW'(ROWS - 1)) begin
                        state_nxt = S_EVAL;
                    end else begin
                        row_nxt = row_idx + RW'(1);
                    end
                end else begin
                    slot_nxt = slot_cnt - SW'(1);
                end
            end
            S_EVAL: begin
                state_nxt = S_SCAN;
                row_nxt   = '0;
                slot_nxt  = SW'(SCAN_DIV - 1);
            end
            default: begin
                state_nxt = S_EVAL;
            end
        endcase
    end

    always_comb begin
        row_o = '1;
        if (state == S_SCAN) begin
            row_o = ~(ROWS'(1) << row_idx);
        end
    end

    // The parked reset state is not a real frame; only evaluate after a scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            have_frame <= 1'b0;
        end else if (state == S_SCAN) begin
            have_frame <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snapshot <= '0;
        end else if (state == S_SCAN && slot_cnt == '0) begin
            for (int r = 0; r < ROWS; r++) begin
                if (RW'(r) == row_idx) begin
                    for (int c = 0; c < COLS; c++) begin
                        snapshot[r*COLS + c] <= col_pressed[c];
                    end
                end
            end
        end
    end

    always_comb begin
        key_cnt    = $countones(snapshot);
        multi_now  = (key_cnt > 1);
        same_frame = (snapshot == prev_frame);
        hit_code   = '0;
        for (int i = 0; i < NK; i++) begin
            if (snapshot[i]) begin
                hit_code = KW'(i);
            end
        end
        do_eval    = (state == S_EVAL) && have_frame;
        // Only the increment that lands on DEBOUNCE_SCANS updates the state;
        // once saturated, a held key does not re-trigger.
        stable_hit = do_eval && !multi_now && same_frame &&
                     (stable_cnt == STW'(DEBOUNCE_SCANS - 1));
        ev_valid   = stable_hit && (key_cnt == 1) && !deb_state[hit_code];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_frame <= '0;
            deb_state  <= '0;
            stable_cnt <= '0;
            multi_o    <= 1'b0;
        end else if (do_eval) begin
            multi_o    <= multi_now;
            prev_frame <= snapshot;
            if (multi_now || !same_frame) begin
                stable_cnt <= '0;
            end else if (stable_cnt != STW'(DEBOUNCE_SCANS)) begin
                stable_cnt <= stable_cnt + STW'(1);
            end
            if (stable_hit) begin
                deb_state <= snapshot;
            end
        end
    end

    keypad_event_buf #(
        .KW (KW)
    ) u_event_buf (
        .clk      (clk),
        .rst      (rst),
        .ev_valid (ev_valid),
        .ev_code  (hit_code),
        .ready    (key_ready_i),
        .valid    (key_valid_o),
        .code     (key_code_o),
        .overflow (overflow_o)
    );

endmodule
